// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
//  Module   : control_seq
//  Purpose  : Multi-cycle control sequencer for the snake CPU datapath.
//             Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
//             Memory accesses use a ready handshake with an optional wait
//             timeout. Opcode decode provides HALT/NOP and traps illegal
//             opcodes.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             opcode [OPW]        - instruction opcode from external IR
//             flag                - ALU compare flag (1 = equal)
//             mem_ready           - memory completes access this cycle
//             c_*                 - datapath strobes (combinational)
//             ir_load             - capture instruction into IR
//             state [3]           - current sequencer state
//             halted, err         - in HALT / sticky trap flag
//  Revision : 1.0 - initial release
// ============================================================================
module control_seq #(
    parameter int OPW        = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           flag,
    input  logic           mem_ready,
    output logic           c_ain,
    output logic           c_bin,
    output logic           c_aout,
    output logic           c_alu,
    output logic           c_imm,
    output logic           c_a,
    output logic           c_b,
    output logic           c_pc_inc,
    output logic           c_pc_load,
    output logic           c_memaddr,
    output logic           c_dataread,
    output logic           c_datawrite,
    output logic           c_regwrite,
    output logic           c_regread,
    output logic           c_lfsr,
    output logic           c_fetch,
    output logic           ir_load,
    output logic [2:0]     state,
    output logic           halted,
    output logic           err
);

    // A zero limit still needs a one-bit counter to keep widths legal.
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_addi = 4'd2;
    localparam logic [3:0] c_op_row  = 4'd3;
    localparam logic [3:0] c_op_col  = 4'd4;
    localparam logic [3:0] c_op_incl = 4'd5;
    localparam logic [3:0] c_op_f    = 4'd6;
    localparam logic [3:0] c_op_ld   = 4'd7;
    localparam logic [3:0] c_op_st   = 4'd8;
    localparam logic [3:0] c_op_je   = 4'd9;
    localparam logic [3:0] c_op_jne  = 4'd10;
    localparam logic [3:0] c_op_j    = 4'd11;
    localparam logic [3:0] c_op_ldi  = 4'd12;
    localparam logic [3:0] c_op_lfsr = 4'd13;
    localparam logic [3:0] c_op_nop  = 4'd14;
    localparam logic [3:0] c_op_halt = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait;
    logic            r_err;
    logic            w_set_err;
    logic            w_illegal;
    logic            w_waiting;
    logic            w_timeout;
    logic [3:0]      w_op;

    assign w_op = opcode[3:0];

    generate
        if (OPW > 4) begin : g_upper_bits
            assign w_illegal = |opcode[OPW-1:4];
        end else begin : g_no_upper_bits
            assign w_illegal = 1'b0;
        end
    endgenerate

    // A request cycle that did not complete.
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

    generate
        if (WAIT_LIMIT != 0) begin : g_timeout
            localparam logic [CW-1:0] c_wait_last = CW'(WAIT_LIMIT - 1);
            assign w_timeout = w_waiting && (r_wait == c_wait_last);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next      = r_state;
        w_set_err   = 1'b0;
        c_ain       = 1'b0;
        c_bin       = 1'b0;
        c_aout      = 1'b0;
        c_alu       = 1'b0;
        c_imm       = 1'b0;
        c_a         = 1'b0;
        c_b         = 1'b0;
        c_pc_inc    = 1'b0;
        c_pc_load   = 1'b0;
        c_memaddr   = 1'b0;
        c_dataread  = 1'b0;
        c_datawrite = 1'b0;
        c_regwrite  = 1'b0;
        c_regread   = 1'b0;
        c_lfsr      = 1'b0;
        c_fetch     = 1'b0;
        ir_load     = 1'b0;

        case (r_state)
            S_IDLE: w_next = S_FETCH;

            S_FETCH: begin
                c_fetch = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    c_pc_inc = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next    = S_HALT;
                    w_set_err = 1'b1;
                end
            end

            S_DECODE: begin
                if (w_illegal) begin
                    w_next    = S_HALT;
                    w_set_err = 1'b1;
                end else begin
                    case (w_op)
                        c_op_add, c_op_sub, c_op_row, c_op_col, c_op_f: begin
                            c_regread = 1'b1;
                            c_ain     = 1'b1;
                            c_bin     = 1'b1;
                            w_next    = S_EXEC;
                        end
                        c_op_addi, c_op_incl: begin
                            c_regread = 1'b1;
                            c_ain     = 1'b1;
                            c_imm     = 1'b1;
                            c_bin     = 1'b1;
                            w_next    = S_EXEC;
                        end
                        c_op_ld, c_op_st: begin
                            c_regread = 1'b1;
                            c_memaddr = 1'b1;
                            w_next    = S_MEM;
                        end
                        c_op_nop:  w_next = S_FETCH;
                        c_op_halt: w_next = S_HALT;
                        default:   w_next = S_EXEC;   // jumps, LDI, LFSR
                    endcase
                end
            end

            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    c_op_add, c_op_addi, c_op_incl: begin
                        c_alu  = 1'b1;
                        w_next = S_WB;
                    end
                    c_op_sub: begin
                        c_alu  = 1'b1;
                        c_a    = 1'b1;
                        w_next = S_WB;
                    end
                    c_op_row: begin
                        c_alu  = 1'b1;
                        c_b    = 1'b1;
                        w_next = S_WB;
                    end
                    c_op_col: begin
                        c_alu  = 1'b1;
                        c_a    = 1'b1;
                        c_b    = 1'b1;
                        w_next = S_WB;
                    end
                    c_op_f: begin
                        // Compare only sets the flag; nothing to write back.
                        c_alu = 1'b1;
                        c_a   = 1'b1;
                    end
                    c_op_je: begin
                        c_imm     = flag;
                        c_pc_load = flag;
                    end
                    c_op_jne: begin
                        c_imm     = !flag;
                        c_pc_load = !flag;
                    end
                    c_op_j: begin
                        c_imm     = 1'b1;
                        c_pc_load = 1'b1;
                    end
                    c_op_ldi: begin
                        c_imm      = 1'b1;
                        c_regwrite = 1'b1;
                    end
                    c_op_lfsr: begin
                        c_lfsr     = 1'b1;
                        c_regwrite = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                // Only LD and ST reach this state.
                if (w_op == c_op_ld) c_dataread = 1'b1;
                else                 c_datawrite = 1'b1;
                if (mem_ready) begin
                    w_next = (w_op == c_op_ld) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next    = S_HALT;
                    w_set_err = 1'b1;
                end
            end

            S_WB: begin
                c_regwrite = 1'b1;
                // LD writes memory data already on the bus.
                if (w_op != c_op_ld) c_aout = 1'b1;
                w_next = S_FETCH;
            end

            S_HALT: w_next = S_HALT;

            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_err) r_err <= 1'b1;
            if (w_next != r_state) r_wait <= '0;
            else if (w_waiting)    r_wait <= r_wait + 1'b1;
        end
    end

    assign state  = r_state;
    assign halted = (r_state == S_HALT);
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_seq
//  Purpose  : Directed self-checking bench for control_seq. One instance with
//             default parameters, one with OPW=6 for illegal-opcode trapping.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_seq;

    // Strobe vector bit masks
    localparam logic [16:0] AIN  = 17'h10000;
    localparam logic [16:0] BIN  = 17'h08000;
    localparam logic [16:0] AOUT = 17'h04000;
    localparam logic [16:0] ALU  = 17'h02000;
    localparam logic [16:0] IMM  = 17'h01000;
    localparam logic [16:0] CA   = 17'h00800;
    localparam logic [16:0] CB   = 17'h00400;
    localparam logic [16:0] PCI  = 17'h00200;
    localparam logic [16:0] PCL  = 17'h00100;
    localparam logic [16:0] MADR = 17'h00080;
    localparam logic [16:0] DRD  = 17'h00040;
    localparam logic [16:0] DWR  = 17'h00020;
    localparam logic [16:0] RW   = 17'h00010;
    localparam logic [16:0] RR   = 17'h00008;
    localparam logic [16:0] LF   = 17'h00004;
    localparam logic [16:0] FET  = 17'h00002;
    localparam logic [16:0] IRL  = 17'h00001;
    localparam logic [16:0] NONE = 17'h00000;

    // Status = {halted, err, state}
    localparam logic [4:0] ST_I  = 5'b00000;
    localparam logic [4:0] ST_F  = 5'b00001;
    localparam logic [4:0] ST_D  = 5'b00010;
    localparam logic [4:0] ST_E  = 5'b00011;
    localparam logic [4:0] ST_M  = 5'b00100;
    localparam logic [4:0] ST_W  = 5'b00101;
    localparam logic [4:0] ST_H  = 5'b10110;
    localparam logic [4:0] ST_HE = 5'b11110;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flag, mem_ready;
    logic [3:0]  opcode;
    logic [16:0] s;
    logic [2:0]  state;
    logic        halted, err;

    logic        rst2, flag2, ready2;
    logic [5:0]  opcode2;
    logic [16:0] s2;
    logic [2:0]  state2;
    logic        halted2, err2;

    int checks = 0;
    int errors = 0;

    control_seq #(.OPW(4), .WAIT_LIMIT(15)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag(flag), .mem_ready(mem_ready),
        .c_ain(s[16]), .c_bin(s[15]), .c_aout(s[14]), .c_alu(s[13]), .c_imm(s[12]),
        .c_a(s[11]), .c_b(s[10]), .c_pc_inc(s[9]), .c_pc_load(s[8]), .c_memaddr(s[7]),
        .c_dataread(s[6]), .c_datawrite(s[5]), .c_regwrite(s[4]), .c_regread(s[3]),
        .c_lfsr(s[2]), .c_fetch(s[1]), .ir_load(s[0]),
        .state(state), .halted(halted), .err(err)
    );

    control_seq #(.OPW(6), .WAIT_LIMIT(15)) u_dut6 (
        .clk(clk), .rst(rst2), .opcode(opcode2), .flag(flag2), .mem_ready(ready2),
        .c_ain(s2[16]), .c_bin(s2[15]), .c_aout(s2[14]), .c_alu(s2[13]), .c_imm(s2[12]),
        .c_a(s2[11]), .c_b(s2[10]), .c_pc_inc(s2[9]), .c_pc_load(s2[8]), .c_memaddr(s2[7]),
        .c_dataread(s2[6]), .c_datawrite(s2[5]), .c_regwrite(s2[4]), .c_regread(s2[3]),
        .c_lfsr(s2[2]), .c_fetch(s2[1]), .ir_load(s2[0]),
        .state(state2), .halted(halted2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic cyc(input string tag, input logic [4:0] st, input logic [16:0] strb);
        #1;
        check({tag, " status"}, {27'd0, halted, err, state}, {27'd0, st});
        check({tag, " strobes"}, {15'd0, s}, {15'd0, strb});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input string tag, input logic [4:0] st, input logic [16:0] strb);
        #1;
        check({tag, " status"}, {27'd0, halted2, err2, state2}, {27'd0, st});
        check({tag, " strobes"}, {15'd0, s2}, {15'd0, strb});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flag = 1'b0; mem_ready = 1'b1; opcode = 4'd0;
        rst2 = 1'b1; flag2 = 1'b0; ready2 = 1'b1; opcode2 = 6'b010000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        cyc("reset", ST_I, NONE);

        // ADD, zero-wait
        opcode = 4'd0;
        cyc("add fetch", ST_F, FET | IRL | PCI);
        cyc("add decode", ST_D, RR | AIN | BIN);
        cyc("add exec", ST_E, ALU);
        cyc("add wb", ST_W, AOUT | RW);

        // JE taken
        opcode = 4'd9; flag = 1'b1;
        cyc("je1 fetch", ST_F, FET | IRL | PCI);
        cyc("je1 decode", ST_D, NONE);
        cyc("je1 exec", ST_E, IMM | PCL);

        // JE not taken: flag high outside EXEC must not matter
        cyc("je0 fetch", ST_F, FET | IRL | PCI);
        cyc("je0 decode", ST_D, NONE);
        flag = 1'b0;
        cyc("je0 exec", ST_E, NONE);

        // JNE with flag=0 is taken
        opcode = 4'd10;
        cyc("jne fetch", ST_F, FET | IRL | PCI);
        cyc("jne decode", ST_D, NONE);
        cyc("jne exec", ST_E, IMM | PCL);

        // SUB
        opcode = 4'd1;
        cyc("sub fetch", ST_F, FET | IRL | PCI);
        cyc("sub decode", ST_D, RR | AIN | BIN);
        cyc("sub exec", ST_E, ALU | CA);
        cyc("sub wb", ST_W, AOUT | RW);

        // COL
        opcode = 4'd4;
        cyc("col fetch", ST_F, FET | IRL | PCI);
        cyc("col decode", ST_D, RR | AIN | BIN);
        cyc("col exec", ST_E, ALU | CA | CB);
        cyc("col wb", ST_W, AOUT | RW);

        // ADDI
        opcode = 4'd2;
        cyc("addi fetch", ST_F, FET | IRL | PCI);
        cyc("addi decode", ST_D, RR | AIN | IMM | BIN);
        cyc("addi exec", ST_E, ALU);
        cyc("addi wb", ST_W, AOUT | RW);

        // F: compare, no writeback
        opcode = 4'd6;
        cyc("f fetch", ST_F, FET | IRL | PCI);
        cyc("f decode", ST_D, RR | AIN | BIN);
        cyc("f exec", ST_E, ALU | CA);

        // LDI and LFSR
        opcode = 4'd12;
        cyc("ldi fetch", ST_F, FET | IRL | PCI);
        cyc("ldi decode", ST_D, NONE);
        cyc("ldi exec", ST_E, IMM | RW);
        opcode = 4'd13;
        cyc("lfsr fetch", ST_F, FET | IRL | PCI);
        cyc("lfsr decode", ST_D, NONE);
        cyc("lfsr exec", ST_E, LF | RW);

        // NOP: two cycles
        opcode = 4'd14;
        cyc("nop fetch", ST_F, FET | IRL | PCI);
        cyc("nop decode", ST_D, NONE);

        // LD with three wait cycles in MEM
        opcode = 4'd7;
        cyc("ld fetch", ST_F, FET | IRL | PCI);
        mem_ready = 1'b0;
        cyc("ld decode", ST_D, RR | MADR);
        cyc("ld mem w1", ST_M, DRD);
        cyc("ld mem w2", ST_M, DRD);
        cyc("ld mem w3", ST_M, DRD);
        mem_ready = 1'b1;
        cyc("ld mem rdy", ST_M, DRD);
        cyc("ld wb", ST_W, RW);

        // ST zero-wait
        opcode = 4'd8;
        cyc("st fetch", ST_F, FET | IRL | PCI);
        cyc("st decode", ST_D, RR | MADR);
        cyc("st mem", ST_M, DWR);

        // HALT opcode: halts without error, stays put
        opcode = 4'd15;
        cyc("halt fetch", ST_F, FET | IRL | PCI);
        cyc("halt decode", ST_D, NONE);
        cyc("halt 1", ST_H, NONE);
        cyc("halt 2", ST_H, NONE);
        do_reset();
        cyc("halt rst", ST_I, NONE);

        // Fetch timeout after exactly 15 request cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("tmo wait%0d", i), ST_F, FET);
        end
        cyc("tmo trap", ST_HE, NONE);
        do_reset();
        cyc("tmo rst", ST_I, NONE);

        // Reset in the middle of a ST memory access
        mem_ready = 1'b1;
        opcode = 4'd8;
        cyc("strst fetch", ST_F, FET | IRL | PCI);
        mem_ready = 1'b0;
        cyc("strst decode", ST_D, RR | MADR);
        cyc("strst mem1", ST_M, DWR);
        rst = 1'b1;
        cyc("strst mem2", ST_M, DWR);
        rst = 1'b0;
        mem_ready = 1'b1;
        cyc("strst idle", ST_I, NONE);
        cyc("strst refetch", ST_F, FET | IRL | PCI);

        // OPW=6 illegal opcode 6'b010000 traps with err
        rst = 1'b1;
        rst2 = 1'b0;
        cyc2("ill idle", ST_I, NONE);
        cyc2("ill fetch", ST_F, FET | IRL | PCI);
        cyc2("ill decode", ST_D, NONE);
        cyc2("ill trap", ST_HE, NONE);
        cyc2("ill hold", ST_HE, NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_seq.md
# control_seq

Parametrised multi-cycle control sequencer for the snake CPU datapath. It replaces single-step opcode decode with an explicit FETCH/DECODE/EXEC/MEM/WB state machine. It adds a memory ready handshake with a wait timeout, a HALT/NOP opcode pair, illegal-opcode trapping and a generalised opcode width. It drives the same datapath strobes (c_*) as the current control unit, plus fetch, IR-load and status outputs.

## Interface
- OPW, 4, opcode width (≥4); opcodes with any bit above bit 3 set are illegal
- WAIT_LIMIT, 15, max cycles waiting on mem_ready before trapping; 0 disables the timeout
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPW  current instruction opcode from the external IR; valid from the cycle after ir_load until the next FETCH
- flag  in  1  ALU compare flag (1 = equal)
- mem_ready  in  1  memory completes the current read/write this cycle
- c_ain, c_bin, c_aout, c_alu, c_imm  out  1  A/B latch enables, ALU result to bus, ALU enable, immediate select
- c_a, c_b  out  1  ALU op select {c_b,c_a}: 00 add, 01 sub, 10 row, 11 col
- c_pc_inc, c_pc_load, c_memaddr, c_dataread, c_datawrite, c_regwrite, c_regread, c_lfsr  out  1  datapath strobes
- c_fetch  out  1  instruction memory read request
- ir_load  out  1  capture instruction into IR
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
- halted  out  1  sequencer is in HALT
- err  out  1  sticky: illegal opcode or memory timeout

## Operation
- All c_*, ir_load: combinational from state, opcode, flag and mem_ready. Each is 0 unless listed for the current state.
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: c_fetch=1.
  - mem_ready=1: ir_load=1, c_pc_inc=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE, by opcode:
  - ADD(0), SUB(1), ROW(3), COL(4), F(6): c_regread, c_ain, c_bin. Go to EXEC.
  - ADDI(2), INCL(5): c_regread, c_ain, c_imm, c_bin. Go to EXEC.
  - LD(7), ST(8): c_regread, c_memaddr. Go to MEM.
  - JE(9), JNE(10), J(11), LDI(12), LFSR(13): no strobes. Go to EXEC.
  - NOP(14): go to FETCH.
  - HALT(15): go to HALT.
  - Illegal (upper bits set): set err, go to HALT.
- EXEC:
  - ALU ops assert c_alu with op select ADD/ADDI/INCL 00, SUB/F 01, ROW 10, COL 11. F then goes to FETCH; the others go to WB.
  - JE: c_imm and c_pc_load if flag=1.
  - JNE: c_imm and c_pc_load if flag=0.
  - J: c_imm and c_pc_load always.
  - Jumps go to FETCH; a not-taken jump asserts nothing.
  - LDI: c_imm, c_regwrite. LFSR: c_lfsr, c_regwrite. Both go to FETCH.
- MEM:
  - LD asserts c_dataread; ST asserts c_datawrite. The strobe is held every cycle until mem_ready=1.
  - On ready: LD goes to WB, ST goes to FETCH.
- WB:
  - ALU ops: c_aout, c_regwrite.
  - LD: c_regwrite only (memory data on bus).
  - Go to FETCH.
- HALT: all strobes 0, halted=1. Only rst exits.
- Wait counter (width $clog2(WAIT_LIMIT+1)):
  - Counts cycles in FETCH/MEM with mem_ready=0; clears on any state change.
  - If WAIT_LIMIT≠0 and counter==WAIT_LIMIT-1 while mem_ready=0, the next state is HALT and err is set. No c_pc_inc is issued on that transition.
- mem_ready outside FETCH/MEM: ignored.

## Timing
- Reset: the edge with rst=1 forces state=IDLE, wait counter=0, err=0.
  - Outputs one cycle after reset: all 0, halted=0, state=0.
  - c_fetch rises the following cycle.
- rst has priority over every transition, including mid-MEM and HALT. A pending memory access is abandoned.
- Cycles per instruction with zero-wait memory (mem_ready=1 on first request cycle):
  - ADD/SUB/ADDI/ROW/COL/INCL/LD: 4
  - F/jumps/LDI/LFSR/ST: 3
  - NOP: 2
- Each cycle of mem_ready=0 adds one cycle.
- A timeout traps after exactly WAIT_LIMIT request cycles.
- c_pc_inc and c_pc_load are never asserted in the same cycle. c_pc_inc pulses exactly once per fetched instruction.
- Jump flag is sampled in the EXEC cycle only; flag changes in other states have no effect.

## Test plan
- Reset then ADD with mem_ready tied 1 → state 0,1,2,3,5,1. c_pc_inc at cycle 1; c_ain/c_bin at 2; c_alu with {c_b,c_a}=00 at 3; c_aout+c_regwrite at 5.
- JE with flag=1, then JE with flag=0 → first EXEC asserts c_pc_load+c_imm; second asserts neither. Both return to FETCH after 3 cycles.
- LD with mem_ready low for 3 MEM cycles → c_dataread held 4 cycles, then WB with c_regwrite. Total 7 cycles. err=0.
- WAIT_LIMIT=15, mem_ready held 0 in FETCH → after 15 cycles state=6, err=1, halted=1, no c_pc_inc. rst=1 → state=0, err=0.
- Opcode 15, then 14 after reset; OPW=6 with opcode 6'b010000 → HALT with err=0; NOP takes 2 cycles; illegal goes to HALT with err=1.
- rst asserted during MEM of ST → c_datawrite drops one cycle after the reset edge, state=IDLE, then FETCH.
